// File: rtl/snes_pad_reader.sv
// -----------------------------------------------------------------------------
// snes_pad_reader
//
// Polls an SNES-style serial gamepad and presents the decoded buttons to the
// game logic. Every POLL_CYC cycles a scan pulses pad_latch, then clocks 16
// bits out of the pad, sampling each bit at the end of its pad_clk low phase.
// The pad's data is active-low. A frame is "good" when wire bits 12..15 all
// read 1. Good frames are committed one cycle after the scan ends. Bad frames
// only raise the sticky pad_error flag.
//
// Optional build macro: SNES_PAD_DEBOUNCE_EN
//   When this macro is defined, a good frame commits only if its 12 decoded
//   bits match the previous good frame. The previous good frame is held in a
//   candidate register. A mismatching good frame replaces the candidate and
//   commits nothing.
//
// Ports:
//   clk               system clock (50 MHz)
//   reset             asynchronous, active-low reset
//   pad_data          serial pad data, active-low, asynchronous to clk
//   pad_latch         latch pulse to the pad
//   pad_clk           shift clock to the pad, idles high
//   controller_report committed buttons {Right,Left,Down,Start,Up,Sel,Y,B}
//   buttons           all 12 committed buttons in wire order, bit0 = B
//   report_valid      one-cycle pulse per committed frame
//   start_rise        one-cycle pulse with report_valid when Start goes 0->1
//   pad_error         sticky; set by a bad frame, cleared by a good commit
// -----------------------------------------------------------------------------
module snes_pad_reader #(
    parameter int POLL_CYC  = 833333,
    parameter int LATCH_CYC = 600,
    parameter int HALF_CYC  = 300
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pad_data,
    output logic        pad_latch,
    output logic        pad_clk,
    output logic [7:0]  controller_report,
    output logic [11:0] buttons,
    output logic        report_valid,
    output logic        start_rise,
    output logic        pad_error
);

    localparam int POLL_W = $clog2(POLL_CYC);
    localparam int PH_MAX = (LATCH_CYC > HALF_CYC) ? LATCH_CYC : HALF_CYC;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    localparam logic [POLL_W-1:0] POLL_LAST  = POLL_W'(POLL_CYC - 1);
    localparam logic [PH_W-1:0]   LATCH_LAST = PH_W'(LATCH_CYC - 1);
    localparam logic [PH_W-1:0]   HALF_LAST  = PH_W'(HALF_CYC - 1);

    typedef enum logic [2:0] {IDLE, LATCH, CLK_LO, CLK_HI, DONE} state_t;

    state_t             state;
    state_t             state_next;
    logic               data_meta;
    logic               data_sync;
    logic [POLL_W-1:0]  poll_cnt;
    logic               poll_wrap;
    logic [PH_W-1:0]    phase;
    logic               phase_last;
    logic [3:0]         bit_idx;
    logic [15:0]        shift;
    logic [11:0]        decoded;
    logic               frame_good;
`ifdef SNES_PAD_DEBOUNCE_EN
    logic [11:0]        candidate;
`endif

    // Two-flop synchronizer. pad_data has no timing relation to clk.
    // NOTE: sequential state uses non-blocking (<=) assignments, so every flop
    // samples its pre-edge inputs and simulation order cannot matter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_meta <= 1'b0;
            data_sync <= 1'b0;
        end else begin
            data_meta <= pad_data;
            data_sync <= data_meta;
        end
    end

    // The poll counter runs freely, including during a scan. The FSM ignores
    // a wrap that occurs outside IDLE.
    assign poll_wrap = (poll_cnt == POLL_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            poll_cnt <= '0;
        end else begin
            poll_cnt <= poll_wrap ? '0 : poll_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The pad outputs decode directly from the state register. A reset
    // therefore returns them to idle levels immediately.
    // NOTE: every always_comb output gets a default first; a path that leaves
    // one unassigned would infer a latch.
    always_comb begin
        state_next = state;
        pad_latch  = 1'b0;
        pad_clk    = 1'b1;
        phase_last = 1'b0;
        case (state)
            IDLE: begin
                if (poll_wrap) state_next = LATCH;
            end
            LATCH: begin
                pad_latch  = 1'b1;
                phase_last = (phase == LATCH_LAST);
                if (phase_last) state_next = CLK_LO;
            end
            CLK_LO: begin
                pad_clk    = 1'b0;
                phase_last = (phase == HALF_LAST);
                if (phase_last) state_next = CLK_HI;
            end
            CLK_HI: begin
                phase_last = (phase == HALF_LAST);
                if (phase_last) state_next = (bit_idx == 4'd15) ? DONE : CLK_LO;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The phase counter times the current LATCH / CLK_LO / CLK_HI interval.
    // The counter restarts at the start of every interval.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase <= '0;
        end else if (state == IDLE || state == DONE || phase_last) begin
            phase <= '0;
        end else begin
            phase <= phase + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_idx <= 4'd0;
        end else if (state == LATCH) begin
            bit_idx <= 4'd0;
        end else if (state == CLK_HI && phase_last) begin
            bit_idx <= bit_idx + 4'd1;
        end
    end

    // Each bit is sampled at the end of its low phase. The pad has then had a
    // full high and low phase to settle, which covers the synchronizer delay.
    // NOTE: the shift register is an ordinary register, not a memory, and it
    // is cleared on reset like every other flop here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift <= 16'h0000;
        end else if (state == CLK_LO && phase_last) begin
            shift[bit_idx] <= data_sync;
        end
    end

    assign decoded    = ~shift[11:0];
    assign frame_good = &shift[15:12];

    // Commit stage. These registers change only while the FSM is in DONE.
    // Their new values appear the cycle after DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buttons           <= 12'h000;
            controller_report <= 8'h00;
            report_valid      <= 1'b0;
            start_rise        <= 1'b0;
            pad_error         <= 1'b0;
`ifdef SNES_PAD_DEBOUNCE_EN
            candidate         <= 12'h000;
`endif
        end else begin
            report_valid <= 1'b0;
            start_rise   <= 1'b0;
            if (state == DONE) begin
                if (!frame_good) begin
                    pad_error <= 1'b1;
                end
`ifdef SNES_PAD_DEBOUNCE_EN
                else if (decoded != candidate) begin
                    candidate <= decoded;
                    pad_error <= 1'b0;
                end
`endif
                else begin
                    buttons           <= decoded;
                    // Report order: Right,Left,Down,Start,Up,Sel,Y,B.
                    // Start and Up swap places relative to wire order.
                    controller_report <= {decoded[7], decoded[6], decoded[5], decoded[3],
                                          decoded[4], decoded[2], decoded[1], decoded[0]};
                    report_valid      <= 1'b1;
                    start_rise        <= decoded[3] & ~buttons[3];
                    pad_error         <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_snes_pad_reader.sv
// -----------------------------------------------------------------------------
// tb_snes_pad_reader
//
// Self-checking bench for snes_pad_reader. The DUT is built with short timing:
// POLL=200, LATCH=4, HALF=2.
// A behavioural pad model reloads its 16-bit word on the pad_latch rising
// edge and shifts on each pad_clk rising edge.
// The reference model works only from the cycle count since reset release.
// From that count it derives the expected pad_latch and pad_clk levels. It
// derives the expected commit results from the word presented to the pad
// during each scan.
// It also follows SNES_PAD_DEBOUNCE_EN when that macro is defined.
// -----------------------------------------------------------------------------
module tb_snes_pad_reader;

    localparam int POLL     = 200;
    localparam int LATCH    = 4;
    localparam int HALF     = 2;
    localparam int COMMIT_O = LATCH + 32 * HALF + 1;  // offset where the commit is visible

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic        pad_data = 1'b1;
    logic        pad_latch;
    logic        pad_clk;
    logic [7:0]  controller_report;
    logic [11:0] buttons;
    logic        report_valid;
    logic        start_rise;
    logic        pad_error;

    always #5 clk = ~clk;

    snes_pad_reader #(
        .POLL_CYC (POLL),
        .LATCH_CYC(LATCH),
        .HALF_CYC (HALF)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .pad_data         (pad_data),
        .pad_latch        (pad_latch),
        .pad_clk          (pad_clk),
        .controller_report(controller_report),
        .buttons          (buttons),
        .report_valid     (report_valid),
        .start_rise       (start_rise),
        .pad_error        (pad_error)
    );

    int checks = 0;
    int errors = 0;
    int unsigned t;  // rising edges since reset release

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0d", name, act, exp, t);
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) t <= 0;
        else        t <= t + 1;
    end

    // ---------------- pad model ----------------
    logic [15:0] pad_word = 16'hFFFF;  // wire-order word the pad will send (active-low)
    logic [15:0] pad_sr   = 16'hFFFF;

    always @(posedge pad_latch or posedge pad_clk) begin
        if (pad_latch) pad_sr = pad_word;
        else           pad_sr = {1'b1, pad_sr[15:1]};
        pad_data = pad_sr[0];
    end

    // ---------------- reference model + compare ----------------
    int          rpt_src [8] = '{0, 1, 2, 4, 3, 5, 6, 7};
    logic [11:0] m_buttons;
    logic [11:0] m_cand;
    logic        m_err;
    logic [15:0] scan_word;
    int          scans_done   = 0;
    int          latch_rise_t = 0;
    int          clk_falls    = 0;
    int          latch_cycles = 0;
    logic        seen_valid   = 1'b0;
    logic        seen_rise    = 1'b0;
    logic        prev_latch   = 1'b0;
    logic        prev_clk     = 1'b1;

    function automatic logic [7:0] to_report(input logic [11:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[rpt_src[i]];
        return r;
    endfunction

    always @(negedge clk) begin
        int          o;
        logic        active;
        logic        exp_latch;
        logic        exp_clk;
        logic        exp_valid;
        logic        exp_rise;
        logic [11:0] dec;
        if (!reset) begin
            check("rst_latch",  pad_latch, 0);
            check("rst_clk",    pad_clk, 1);
            check("rst_report", controller_report, 0);
            check("rst_buttons", buttons, 0);
            check("rst_valid",  report_valid, 0);
            check("rst_rise",   start_rise, 0);
            check("rst_err",    pad_error, 0);
            m_buttons  = 12'h000;
            m_cand     = 12'h000;
            m_err      = 1'b0;
            prev_latch = 1'b0;
            prev_clk   = 1'b1;
        end else begin
            active    = (t >= POLL);
            o         = int'(t % POLL);
            exp_latch = active && (o < LATCH);
            exp_clk   = !(active && o >= LATCH && o < LATCH + 32 * HALF &&
                          ((o - LATCH) / HALF) % 2 == 0);
            exp_valid = 1'b0;
            exp_rise  = 1'b0;
            if (active && o == 0) begin
                scan_word    = pad_word;
                seen_valid   = 1'b0;
                seen_rise    = 1'b0;
                clk_falls    = 0;
                latch_cycles = 0;
            end
            if (active && o == COMMIT_O) begin
                dec = ~scan_word[11:0];
                if (scan_word[15:12] != 4'hF) m_err = 1'b1;
`ifdef SNES_PAD_DEBOUNCE_EN
                else if (dec != m_cand) begin
                    m_cand = dec;
                    m_err  = 1'b0;
                end
`endif
                else begin
                    exp_valid = 1'b1;
                    exp_rise  = dec[3] && !m_buttons[3];
                    m_buttons = dec;
                    m_err     = 1'b0;
                end
                scans_done++;
            end
            check("pad_latch", pad_latch, exp_latch);
            check("pad_clk", pad_clk, exp_clk);
            check("report_valid", report_valid, exp_valid);
            check("start_rise", start_rise, exp_rise);
            check("buttons", buttons, m_buttons);
            check("controller_report", controller_report, to_report(m_buttons));
            check("pad_error", pad_error, m_err);
            if (pad_latch && !prev_latch) latch_rise_t = int'(t);
            if (!pad_clk && prev_clk) clk_falls++;
            if (pad_latch) latch_cycles++;
            if (report_valid) seen_valid = 1'b1;
            if (start_rise) seen_rise = 1'b1;
            prev_latch = pad_latch;
            prev_clk   = pad_clk;
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_scan(input logic [15:0] w);
        int   n;
        logic done;
        pad_word = w;
        n        = scans_done;
        done     = 1'b0;
        for (int i = 0; i < 3 * POLL && !done; i++) begin
            @(negedge clk);
            if (scans_done != n) done = 1'b1;
        end
        check("scan_done", done, 1);
        @(negedge clk);
    endtask

    initial begin
        logic        hit;
        logic [15:0] w;
        int          reps;
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;

`ifndef SNES_PAD_DEBOUNCE_EN
        do_scan(16'hFFFF);  // unplugged / nothing pressed
        check("first_latch_t", latch_rise_t, 200);
        check("latch_cycles", latch_cycles, 4);
        check("clk_falls", clk_falls, 16);
        check("idle_seen_valid", seen_valid, 1);
        check("idle_report", controller_report, 8'h00);
        check("idle_err", pad_error, 0);

        do_scan(16'hFFF7);  // Start pressed
        check("start_report", controller_report, 8'h10);
        check("start_buttons", buttons, 12'h008);
        check("start_seen_valid", seen_valid, 1);
        check("start_seen_rise", seen_rise, 1);

        do_scan(16'hFFF7);  // Start held
        check("held_seen_valid", seen_valid, 1);
        check("held_seen_rise", seen_rise, 0);

        do_scan(16'hBFFE);  // wire bit14 low, so the frame is bad
        check("bad_seen_valid", seen_valid, 0);
        check("bad_report", controller_report, 8'h10);
        check("bad_err", pad_error, 1);

        do_scan(16'hFFFF);
        check("recover_err", pad_error, 0);
        check("recover_seen_valid", seen_valid, 1);
        check("recover_report", controller_report, 8'h00);
`else
        do_scan(16'hFFFF);  // decodes to 0, which matches the reset candidate
        check("db_idle_seen_valid", seen_valid, 1);
        do_scan(16'hFFEF);  // Up, first sighting
        check("db_up1_seen_valid", seen_valid, 0);
        check("db_up1_report", controller_report, 8'h00);
        do_scan(16'hFFEF);  // Up, confirmed
        check("db_up2_seen_valid", seen_valid, 1);
        check("db_up2_report", controller_report, 8'h08);
`endif

        // Reset during the CLK_LO phase of bit 7.
        hit = 1'b0;
        for (int i = 0; i < 3 * POLL && !hit; i++) begin
            @(negedge clk);
            if (t >= POLL && (t % POLL) == 32) hit = 1'b1;
        end
        check("reset_point_found", hit, 1);
        check("mid_scan_clk_low", pad_clk, 0);
        #2 reset = 1'b0;
        #1;
        check("abort_clk", pad_clk, 1);
        check("abort_latch", pad_latch, 0);
        check("abort_report", controller_report, 8'h00);
        check("abort_buttons", buttons, 12'h000);
        check("abort_err", pad_error, 0);
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;

        do_scan(16'hF67F);  // Right + A + R
        check("post_reset_latch_t", latch_rise_t, 200);
`ifdef SNES_PAD_DEBOUNCE_EN
        do_scan(16'hF67F);
`endif
        check("rar_buttons", buttons, 12'h980);
        check("rar_report", controller_report, 8'h80);

        // Random frames. About one in five is bad, and some repeat, so holds,
        // releases and debounce confirmation are all exercised.
        for (int k = 0; k < 24; k++) begin
            w[11:0]  = 12'($urandom_range(0, 4095));
            w[15:12] = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
            reps     = int'($urandom_range(1, 2));
            for (int r = 0; r < reps; r++) do_scan(w);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/snes_pad_reader.md
Name: snes_pad_reader

Overview:
- Produces the 8-bit `controller_report` consumed by the game display/logic block. Bit 4 is Start, which requests replay after game over.
- Polls a serial SNES-style gamepad: pulses latch, clocks out 16 bits, and decodes the active-low data into button levels.
- Registers each completed frame and emits a one-cycle valid strobe plus a Start rising-edge pulse.
- Sits between the FPGA GPIO pad pins and the game logic, in the 50 MHz domain.

Parameters:
- POLL_CYC, 833333: clk cycles between poll starts (60 Hz at 50 MHz).
- LATCH_CYC, 600: latch-high duration in clk cycles (12 us).
- HALF_CYC, 300: duration of each pad_clk low or high phase (6 us).

Ports:
- `clk` in 1: system clock, 50 MHz.
- `reset` in 1: asynchronous, active-low reset.
- `pad_data` in 1: serial data from the pad; active-low button state; asynchronous to `clk`.
- `pad_latch` out 1: latch pulse to the pad.
- `pad_clk` out 1: shift clock to the pad; idles high.
- `controller_report` out 8: committed buttons. [0]=B, [1]=Y, [2]=Select, [3]=Up, [4]=Start, [5]=Down, [6]=Left, [7]=Right.
- `buttons` out 12: all decoded buttons in wire order B,Y,Sel,Start,Up,Down,Left,Right,A,X,L,R; bit0 = B.
- `report_valid` out 1: one-cycle pulse when a frame is committed.
- `start_rise` out 1: one-cycle pulse, concurrent with `report_valid`, when committed Start goes 0->1.
- `pad_error` out 1: sticky flag; set by a bad frame, cleared by the next good commit.

Behaviour:
- Reset (`reset`=0, asynchronous):
  - `pad_latch`=0, `pad_clk`=1.
  - `controller_report`=0, `buttons`=0.
  - `report_valid`=0, `start_rise`=0, `pad_error`=0.
  - FSM to IDLE; poll counter, bit index, shift register and synchronizer cleared.
  - A reset asserted mid-scan aborts the scan immediately; no partial frame is ever committed.
- Input sync: `pad_data` passes through a 2-flop synchronizer; all sampling uses the synchronized value.
- Poll counter: free-running, 0..POLL_CYC-1, wraps to 0. The wrap cycle starts a scan.
  - It keeps counting during a scan.
  - A wrap while not in IDLE is ignored (scan length must be < POLL_CYC).
  - First scan starts POLL_CYC cycles after reset release.
- FSM:
  - IDLE: latch=0, clk=1. Poll wrap -> LATCH.
  - LATCH: latch=1 for LATCH_CYC cycles -> CLK_LO with bit index=0.
  - CLK_LO: clk=0 for HALF_CYC cycles. On the last cycle, shift[bit] <= synchronized `pad_data`. Then -> CLK_HI.
  - CLK_HI: clk=1 for HALF_CYC cycles, then bit++. If bit was 15 -> DONE, else -> CLK_LO.
  - DONE: one cycle, -> IDLE.
- Scan length: LATCH_CYC + 32*HALF_CYC + 1 cycles.
- Decode: `buttons[i]` = ~shift[i] for i in 0..11. Wire bits 12..15 must read 1.
- Commit in DONE, with outputs registered (visible the cycle after DONE):
  - Good frame (shift[15:12]==4'hF): update `buttons` and `controller_report`; pulse `report_valid`; pulse `start_rise` if new Start=1 and old Start=0; clear `pad_error`.
  - Bad frame (any of shift[15:12]=0): no update; no `report_valid`, no `start_rise`; set `pad_error`=1.
- Unplugged pad reads all 1s, giving a good frame with all buttons released (report 0).
- Start held across frames: `start_rise` fires only on the first frame.

Optional Feature:
- Macro: SNES_PAD_DEBOUNCE_EN.
- Defined:
  - A good frame commits only if its decoded 12 bits equal the previous good frame's bits, held in a candidate register.
  - Otherwise the candidate is updated and nothing commits: no `report_valid`, `pad_error` cleared.
  - Press-to-report latency is 2 polls; the candidate register resets to 0.
  - Bad frames leave the candidate untouched.
- Undefined: every good frame commits.

Test Plan (bench params LATCH_CYC=4, HALF_CYC=2, POLL_CYC=200):
- Reset release, pad_data held 1 -> first latch rises at cycle 200; latch high 4 cycles; 16 low/high clk pulses of 2 cycles each; `report_valid` pulse with `controller_report`=0, `pad_error`=0.
- Pad model drives Start pressed (wire bit3=0, rest 1) -> `controller_report`=8'h10, `buttons`=12'h008, `start_rise`=1 for one cycle. Next identical frame -> `report_valid`=1, `start_rise`=0.
- Frame with wire bit14=0, B pressed -> no `report_valid`, `report` unchanged, `pad_error`=1. Next good frame clears `pad_error`.
- Assert reset during CLK_LO of bit 7 -> `pad_clk`=1 and `pad_latch`=0 immediately; all outputs 0; no commit. Next scan at 200 cycles after release.
- Right+A+R pressed (wire bits 7,8,11=0) -> `buttons`=12'h980, `controller_report`=8'h80.
- With SNES_PAD_DEBOUNCE_EN: Up pressed -> first frame no `report_valid`; second frame `report_valid`, `controller_report`=8'h08.
